// File: rtl/conv33_pkg.sv
// Shared constants and window index mapping for the 3x3 convolution window path.
// Window index k = row*3 + col; row 0 is the oldest line, col 2 the newest column.
package conv33_pkg;
   localparam int PIX_W    = 8;
   localparam int WIN_N    = 9;
   localparam int WIN_DIM  = 3;
   localparam int WIN_TL   = 0;
   localparam int WIN_TR   = 2;
   localparam int WIN_BR   = 8;

   typedef logic [PIX_W-1:0] pix_t;

   function automatic int win_idx(input int r, input int c);
      return r * WIN_DIM + c;
   endfunction
endpackage

// File: rtl/conv33_line_buffer.sv
// One image row of delay: an enable-gated shift register, DEPTH pixels long.
// Contents are intentionally not reset; stale data never reaches a valid window.
module conv33_line_buffer
   import conv33_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [PIX_W-1:0] din_i,
   output logic [PIX_W-1:0] dout_o
);
   pix_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign dout_o = mem_q[DEPTH-1];
endmodule

// File: rtl/conv33_window_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a shifting 3x3 register
// window, emitting only fully-inside windows through a single output register.
module conv33_window_gen
   import conv33_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             in_ready,
   output logic [PIX_W-1:0] win_0,
   output logic [PIX_W-1:0] win_1,
   output logic [PIX_W-1:0] win_2,
   output logic [PIX_W-1:0] win_3,
   output logic [PIX_W-1:0] win_4,
   output logic [PIX_W-1:0] win_5,
   output logic [PIX_W-1:0] win_6,
   output logic [PIX_W-1:0] win_7,
   output logic [PIX_W-1:0] win_8,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          accept;
   logic          col_end, row_end;
   pix_t          lb1_out, lb2_out;
   pix_t          col_src [WIN_DIM];
   pix_t          win_q [WIN_N];
   pix_t          win_d [WIN_N];

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign col_end  = (col_q == CW'(IMG_W-1));
   assign row_end  = (row_q == RW'(IMG_H-1));

   conv33_line_buffer #(.DEPTH(IMG_W)) u_line1 (
      .clk    (clk),
      .en_i   (accept),
      .din_i  (in_pixel),
      .dout_o (lb1_out)
   );

   conv33_line_buffer #(.DEPTH(IMG_W)) u_line2 (
      .clk    (clk),
      .en_i   (accept),
      .din_i  (lb1_out),
      .dout_o (lb2_out)
   );

   // New right-hand column: oldest line on top, incoming pixel at the bottom.
   assign col_src[0] = lb2_out;
   assign col_src[1] = lb1_out;
   assign col_src[2] = in_pixel;

   for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_row
      for (genvar gj = 0; gj < WIN_DIM; gj++) begin : g_col
         if (gj < WIN_DIM-1) begin : g_shift
            assign win_d[win_idx(gi, gj)] = accept ? win_q[win_idx(gi, gj+1)]
                                                   : win_q[win_idx(gi, gj)];
         end else begin : g_load
            assign win_d[win_idx(gi, gj)] = accept ? col_src[gi]
                                                   : win_q[win_idx(gi, gj)];
         end
      end
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (accept) begin
         // Windows exist only once two earlier rows and columns are in place.
         out_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
         out_last_d  = row_end && col_end;
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < WIN_N; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         for (int i = 0; i < WIN_N; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign win_0 = win_q[WIN_TL];
   assign win_1 = win_q[1];
   assign win_2 = win_q[WIN_TR];
   assign win_3 = win_q[3];
   assign win_4 = win_q[4];
   assign win_5 = win_q[5];
   assign win_6 = win_q[6];
   assign win_7 = win_q[7];
   assign win_8 = win_q[WIN_BR];
endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench for conv33_window_gen: a 4x4 instance for the directed frames and
// an 8x8 instance for the randomly throttled frame, sharing one stimulus set.
module tb_conv33_window_gen;
   typedef struct packed {
      logic            last;
      logic [8:0][7:0] w;
   } win_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_pixel;
   logic       out_ready;

   logic       in_ready4, out_valid4, out_last4;
   logic       in_ready8, out_valid8, out_last8;
   logic [7:0] w4 [9];
   logic [7:0] w8 [9];

   logic            sel;
   logic            c_in_ready, c_out_valid, c_out_last;
   logic [8:0][7:0] cw;

   win_t       exp_q [$];
   logic [7:0] src_q [$];

   int chk = 0;
   int err = 0;
   int acc_cnt, win_cnt, last_cnt, sum;

   always #5 clk = ~clk;

   conv33_window_gen #(.IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
      .in_ready(in_ready4),
      .win_0(w4[0]), .win_1(w4[1]), .win_2(w4[2]), .win_3(w4[3]), .win_4(w4[4]),
      .win_5(w4[5]), .win_6(w4[6]), .win_7(w4[7]), .win_8(w4[8]),
      .out_valid(out_valid4), .out_ready(out_ready), .out_last(out_last4)
   );

   conv33_window_gen #(.IMG_W(8), .IMG_H(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
      .in_ready(in_ready8),
      .win_0(w8[0]), .win_1(w8[1]), .win_2(w8[2]), .win_3(w8[3]), .win_4(w8[4]),
      .win_5(w8[5]), .win_6(w8[6]), .win_7(w8[7]), .win_8(w8[8]),
      .out_valid(out_valid8), .out_ready(out_ready), .out_last(out_last8)
   );

   always_comb begin
      c_in_ready  = sel ? in_ready8  : in_ready4;
      c_out_valid = sel ? out_valid8 : out_valid4;
      c_out_last  = sel ? out_last8  : out_last4;
      for (int k = 0; k < 9; k++) begin
         cw[k] = sel ? w8[k] : w4[k];
      end
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      chk++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected window with top-left pixel index tl in a frame of width w.
   task automatic push_win(input int base, input int w, input int tl, input bit last);
      win_t e;
      for (int k = 0; k < 9; k++) begin
         e.w[k] = 8'(base + tl + (k / 3) * w + (k % 3));
      end
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic clear_counts();
      acc_cnt  = 0;
      win_cnt  = 0;
      last_cnt = 0;
      sum      = 0;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive src_q through the DUT from a negedge; consume windows against exp_q.
   task automatic run(input int budget, input int stall, input bit rnd, input int exp_first);
      int   cyc = 0;
      bit   seen = 1'b0;
      int   stall_left = stall;
      bit   stalling;
      logic [71:0] held = '0;
      win_t e;
      forever begin
         if (src_q.size() == 0 && exp_q.size() == 0 && !c_out_valid) break;
         if (cyc >= budget) begin
            check("run_budget", 80'(src_q.size() + exp_q.size()), 80'(0));
            break;
         end
         if (c_out_valid && !seen) begin
            seen = 1'b1;
            held = cw;
            check("first_latency", 80'(acc_cnt), 80'(exp_first));
         end
         stalling = seen && (stall_left > 0);
         if (stalling) begin
            out_ready = 1'b0;
            check("stall_valid", 80'(c_out_valid), 80'(1));
            check("stall_win", 80'(cw), 80'(held));
         end else begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         in_valid = (src_q.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         in_pixel = in_valid ? src_q[0] : 8'($urandom);
         #1;
         if (stalling) begin
            check("stall_in_ready", 80'(c_in_ready), 80'(0));
            stall_left--;
         end
         if (in_valid && c_in_ready) begin
            void'(src_q.pop_front());
            acc_cnt++;
         end
         if (c_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("window_expected", 80'(exp_q.size() > 0), 80'(1));
            end else begin
               e = exp_q.pop_front();
               check("win", 80'(cw), 80'(e.w));
               check("last", 80'(c_out_last), 80'(e.last));
               win_cnt++;
               last_cnt += int'(c_out_last);
               for (int k = 0; k < 9; k++) sum += int'(cw[k]);
            end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic push_frame4(input int base);
      for (int i = 0; i < 16; i++) src_q.push_back(8'(base + i));
      push_win(base, 4, 0, 1'b0);
      push_win(base, 4, 1, 1'b0);
      push_win(base, 4, 4, 1'b0);
      push_win(base, 4, 5, 1'b1);
   endtask

   initial begin
      sel       = 1'b0;
      in_valid  = 1'b0;
      in_pixel  = 8'd0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 80'(c_out_valid), 80'(0));
      check("rst_out_last", 80'(c_out_last), 80'(0));
      check("rst_in_ready", 80'(c_in_ready), 80'(1));
      check("rst_win", 80'(cw), 80'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Single 4x4 frame, always ready.
      clear_counts();
      push_frame4(0);
      run(200, 0, 1'b0, 11);
      check("f1_windows", 80'(win_cnt), 80'(4));
      check("f1_lasts", 80'(last_cnt), 80'(1));
      $display("frame1 4x4: windows=%0d lasts=%0d", win_cnt, last_cnt);

      // Same frame with a 5-cycle stall on the first window.
      do_reset();
      clear_counts();
      push_frame4(0);
      run(200, 5, 1'b0, 11);
      check("stall_windows", 80'(win_cnt), 80'(4));
      $display("stall 4x4: windows=%0d accepts=%0d", win_cnt, acc_cnt);

      // Two frames back to back.
      do_reset();
      clear_counts();
      push_frame4(0);
      push_frame4(100);
      run(300, 0, 1'b0, 11);
      check("b2b_windows", 80'(win_cnt), 80'(8));
      check("b2b_lasts", 80'(last_cnt), 80'(2));
      $display("back-to-back 4x4: windows=%0d lasts=%0d", win_cnt, last_cnt);

      // Reset after 7 accepts, then a clean frame.
      do_reset();
      clear_counts();
      for (int i = 0; i < 7; i++) src_q.push_back(8'(200 + i));
      run(100, 0, 1'b0, 11);
      check("partial_accepts", 80'(acc_cnt), 80'(7));
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 80'(c_out_valid), 80'(0));
      check("midrst_win", 80'(cw), 80'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_counts();
      push_frame4(0);
      run(200, 0, 1'b0, 11);
      check("midrst_windows", 80'(win_cnt), 80'(4));
      $display("mid-frame reset 4x4: windows=%0d", win_cnt);

      // 8x8 frame with random valid/ready throttling.
      sel = 1'b1;
      do_reset();
      clear_counts();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) src_q.push_back(8'(r * 8 + c));
      for (int r = 2; r < 8; r++)
         for (int c = 2; c < 8; c++) push_win(0, 8, (r - 2) * 8 + (c - 2), (r == 7 && c == 7));
      run(3000, 0, 1'b1, 19);
      check("rnd_windows", 80'(win_cnt), 80'(36));
      check("rnd_lasts", 80'(last_cnt), 80'(1));
      check("rnd_golden_sum", 80'(sum), 80'(10206));
      $display("random 8x8: windows=%0d sum=%0d", win_cnt, sum);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule
